// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one signed 8x8 booth_multiplier between two requesters.
// It loads A then B over select/multIn, waits LATENCY cycles and returns the captured product.
`timescale 1ns/1ps

module booth_mult_arbiter #(
    parameter int LATENCY = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_a0,
    input  logic [7:0]  req_b0,
    input  logic [7:0]  req_a1,
    input  logic [7:0]  req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic        mul_select,
    output logic [7:0]  mul_in,
    input  logic [15:0] mul_product,
    output logic        busy,
    output logic [15:0] ops_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] WAIT_INIT = 8'(LATENCY - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        mul_select_q, mul_select_d;
    logic [7:0]  mul_in_q, mul_in_d;
    logic [15:0] ops_done_q, ops_done_d;

    logic [1:0]  grant;
    logic        accept;
    logic        acc_id;
    logic [7:0]  acc_a;
    logic [7:0]  acc_b;

    // Valid/ready on both ports: a transfer happens on the rising edge where valid and ready
    // are both high; the sender holds valid and its payload stable until that edge.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = (state_q == S_IDLE && !reset) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign acc_id    = req_ready[1];
    assign acc_a     = acc_id ? req_a1 : req_a0;
    assign acc_b     = acc_id ? req_b1 : req_b0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        mul_select_d = mul_select_q;
        mul_in_d     = mul_in_q;
        ops_done_d   = ops_done_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_LOAD_A;
                    id_d         = acc_id;
                    b_d          = acc_b;
                    ptr_d        = ~acc_id;
                    mul_select_d = 1'b1;
                    mul_in_d     = acc_a;
                end
            end
            S_LOAD_A: begin
                state_d      = S_LOAD_B;
                mul_select_d = 1'b0;
                mul_in_d     = b_q;
            end
            S_LOAD_B: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_INIT;
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d     = S_DONE;
                    rsp_data_d  = mul_product;
                    rsp_valid_d = id_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                // Only the owning requester's ready retires the result.
                if (rsp_ready[id_q]) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 2'b00;
                    ops_done_d  = ops_done_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            id_q         <= 1'b0;
            b_q          <= 8'd0;
            cnt_q        <= 8'd0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= 16'd0;
            mul_select_q <= 1'b0;
            mul_in_q     <= 8'd0;
            ops_done_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            mul_select_q <= mul_select_d;
            mul_in_q     <= mul_in_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign mul_select = mul_select_q;
    assign mul_in     = mul_in_q;
    assign busy       = (state_q != S_IDLE);
    assign ops_done   = ops_done_q;
    assign dbg_state  = state_q;

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid_q));
    a_select_in_load_a: assert property (@(posedge clk) disable iff (reset)
                                         mul_select_q |-> (state_q == S_LOAD_A));

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-timeline model; a second LATENCY=1 instance covers the short-latency and wrap cases.
`timescale 1ns/1ps

module tb_booth_mult_arbiter;

    localparam int L0 = 8;
    localparam int L1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h80;
            1: return 8'h7F;
            2: return 8'hFF;
            3: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- main instance (LATENCY = 8) ----------------
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  rsp_ready = 2'b11;
    logic [7:0]  op_a [2] = '{8'd0, 8'd0};
    logic [7:0]  op_b [2] = '{8'd0, 8'd0};
    logic [1:0]  req_ready, rsp_valid;
    logic [15:0] rsp_data, mul_product, ops_done;
    logic        mul_select, busy;
    logic [7:0]  mul_in;
    logic [2:0]  dbg_state;

    booth_mult_arbiter #(.LATENCY(L0)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(op_a[0]), .req_b0(op_b[0]), .req_a1(op_a[1]), .req_b1(op_b[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_select(mul_select), .mul_in(mul_in), .mul_product(mul_product),
        .busy(busy), .ops_done(ops_done), .dbg_state(dbg_state)
    );

    // Multiplier model: select=1 loads A, the first select=0 edge after that loads B and
    // starts the latency count; the product is corrupted until the count expires.
    logic [7:0] ma_q = 8'd0, mb_q = 8'd0;
    logic       mpend = 1'b0;
    int         mcnt = 0;
    always @(posedge clk) begin
        if (mul_select) begin
            ma_q  <= mul_in;
            mpend <= 1'b1;
        end else begin
            mb_q <= mul_in;
            if (mpend) begin
                mpend <= 1'b0;
                mcnt  <= L0 - 1;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
            end
        end
    end
    assign mul_product = (mcnt == 0) ? prod(ma_q, mb_q) : (prod(ma_q, mb_q) ^ 16'hA5A5);

    // ---------------- second instance (LATENCY = 1) ----------------
    logic [1:0]  s_req_valid = 2'b00;
    logic [1:0]  s_rsp_ready = 2'b11;
    logic [7:0]  s_op_a = 8'd0, s_op_b = 8'd0;
    logic [1:0]  s_req_ready, s_rsp_valid;
    logic [15:0] s_rsp_data, s_mul_product, s_ops_done;
    logic        s_mul_select, s_busy;
    logic [7:0]  s_mul_in;
    logic [2:0]  s_dbg_state;

    booth_mult_arbiter #(.LATENCY(L1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a0(s_op_a), .req_b0(s_op_b), .req_a1(8'd0), .req_b1(8'd0),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .mul_select(s_mul_select), .mul_in(s_mul_in), .mul_product(s_mul_product),
        .busy(s_busy), .ops_done(s_ops_done), .dbg_state(s_dbg_state)
    );

    logic [7:0] sa_q = 8'd0, sb_q = 8'd0;
    logic       spend = 1'b0;
    int         scnt = 0;
    always @(posedge clk) begin
        if (s_mul_select) begin
            sa_q  <= s_mul_in;
            spend <= 1'b1;
        end else begin
            sb_q <= s_mul_in;
            if (spend) begin
                spend <= 1'b0;
                scnt  <= L1 - 1;
            end else if (scnt > 0) begin
                scnt <= scnt - 1;
            end
        end
    end
    assign s_mul_product = (scnt == 0) ? prod(sa_q, sb_q) : (prod(sa_q, sb_q) ^ 16'hA5A5);

    // ---------------- reference model for the main instance ----------------
    // Tracks each operation as a timeline: phase 0 is the accept cycle, A is on the pins in
    // phase 1, the response is due from phase L0+3 until the owner's rsp_ready.
    logic        m_busy = 1'b0;
    int          m_phase = 0;
    logic        m_id = 1'b0;
    logic [7:0]  m_a = 8'd0, m_b = 8'd0, m_last_b = 8'd0;
    logic        m_ptr = 1'b0;
    logic [15:0] m_ops = 16'd0;
    logic [15:0] exp_q [$];

    always @(negedge clk) begin
        logic [1:0] g;
        logic [1:0] exp_rv;
        if (reset) begin
            m_busy   = 1'b0;
            m_phase  = 0;
            m_ptr    = 1'b0;
            m_ops    = 16'd0;
            m_last_b = 8'd0;
            exp_q.delete();
        end else begin
            g = 2'b00;
            if (!m_busy) begin
                if (req_valid == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
                else g = req_valid;
            end
            exp_rv = (m_busy && m_phase >= L0 + 3) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
            chk("m_req_ready", 32'(req_ready), 32'(g));
            chk("m_busy", 32'(busy), 32'(m_busy));
            chk("m_mul_select", 32'(mul_select), 32'(m_busy && m_phase == 1));
            chk("m_mul_in", 32'(mul_in), 32'((m_busy && m_phase == 1) ? m_a : m_last_b));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("m_ops_done", 32'(ops_done), 32'(m_ops));
            if (exp_rv != 2'b00) chk("m_rsp_data", 32'(rsp_data), 32'(exp_q[0]));

            if (!m_busy) begin
                if (g != 2'b00) begin
                    m_busy  = 1'b1;
                    m_phase = 1;
                    m_id    = g[1];
                    m_a     = op_a[g[1]];
                    m_b     = op_b[g[1]];
                    m_ptr   = ~g[1];
                    exp_q.push_back(prod(m_a, m_b));
                end
            end else if (exp_rv != 2'b00) begin
                if (rsp_ready[m_id]) begin
                    m_busy = 1'b0;
                    m_ops  = m_ops + 16'd1;
                    void'(exp_q.pop_front());
                end
            end else begin
                if (m_phase == 1) m_last_b = m_b;
                m_phase++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_mul_select"}, 32'(mul_select), 32'd0);
        chk({tag, "_mul_in"}, 32'(mul_in), 32'd0);
        chk({tag, "_ops_done"}, 32'(ops_done), 32'd0);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 after the response is seen.
    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
        int  t_acc;
        bit  ok;
        op_a[id] = a;
        op_b[id] = b;
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1'b1; break; end
        end
        chk("op_accept_seen", 32'(ok), 32'd1);
        t_acc = cyc;
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        @(negedge clk);
        chk("op_loadA_select", 32'(mul_select), 32'd1);
        chk("op_loadA_in", 32'(mul_in), 32'(a));
        @(negedge clk);
        chk("op_loadB_select", 32'(mul_select), 32'd0);
        chk("op_loadB_in", 32'(mul_in), 32'(b));
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin ok = 1'b1; break; end
        end
        chk("op_rsp_seen", 32'(ok), 32'd1);
        chk("op_rsp_latency", 32'(cyc - t_acc), 32'(L0 + 3));
        chk("op_rsp_data", 32'(rsp_data), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_op1(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input logic [15:0] exp_ops);
        int t_acc;
        bit ok;
        s_op_a = a;
        s_op_b = b;
        s_req_valid = 2'b01;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_req_ready[0]) begin ok = 1'b1; break; end
        end
        chk("l1_accept_seen", 32'(ok), 32'd1);
        t_acc = cyc;
        @(posedge clk);
        #1 s_req_valid = 2'b00;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (s_rsp_valid != 2'b00) begin ok = 1'b1; break; end
        end
        chk("l1_rsp_seen", 32'(ok), 32'd1);
        chk("l1_rsp_latency", 32'(cyc - t_acc), 32'(L1 + 3));
        chk("l1_rsp_valid", 32'(s_rsp_valid), 32'd1);
        chk("l1_rsp_data", 32'(s_rsp_data), 32'(exp));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("l1_ops_done", 32'(s_ops_done), 32'(exp_ops));
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenario sequence ----------------
    initial begin
        logic [1:0] g;
        logic [1:0] hs;
        int         ord [4];
        int         ng, nrsp;
        bit         ok;

        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1;

        // Signed corners on requester 0.
        do_op(0, 8'h80, 8'h80, 16'h4000);
        do_op(0, 8'h7F, 8'h80, 16'hC080);
        do_op(0, 8'hFF, 8'hFF, 16'h0001);

        // Contention: both requesters valid straight out of reset.
        reset = 1'b1;
        req_valid = 2'b11;
        op_a[0] = 8'h11; op_b[0] = 8'h22; op_a[1] = 8'hF0; op_b[1] = 8'h0F;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        rsp_ready = 2'b11;
        ord = '{-1, -1, -1, -1};
        ng = 0;
        nrsp = 0;
        for (int n = 0; n < 400 && nrsp < 4; n++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                chk("cont_rsp_owner", 32'(rsp_valid), 32'(ord[nrsp] == 1 ? 2'b10 : 2'b01));
                nrsp++;
            end
            @(posedge clk);
            #1;
            if (g != 2'b00 && ng < 4) begin
                ord[ng] = int'(g[1]);
                ng++;
                if (ng >= 3) req_valid[g[1]] = 1'b0;
                else begin
                    op_a[g[1]] = pick();
                    op_b[g[1]] = pick();
                end
            end
        end
        chk("cont_done", 32'(nrsp), 32'd4);
        chk("cont_grant0", 32'(ord[0]), 32'd0);
        chk("cont_grant1", 32'(ord[1]), 32'd1);
        chk("cont_grant2", 32'(ord[2]), 32'd0);
        chk("cont_grant3", 32'(ord[3]), 32'd1);
        @(negedge clk);
        chk("cont_ops_done", 32'(ops_done), 32'd4);
        @(posedge clk);
        #1;

        // Response backpressure; the other id's ready must not retire the result.
        rsp_ready = 2'b10;
        do_op(0, 8'h37, 8'hC5, 16'hF353);
        op_a[1] = 8'h12;
        op_b[1] = 8'h34;
        req_valid[1] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'hF353);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        rsp_ready = 2'b01;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        rsp_ready = 2'b11;
        repeat (20) @(posedge clk);
        #1;

        // Reset while the operation sits in WAIT.
        op_a[0] = 8'h5A;
        op_b[0] = 8'h3C;
        req_valid[0] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin ok = 1'b1; break; end
        end
        chk("abort_accept_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("abort");
        repeat (20) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 2'b11;
        op_a[0] = pick(); op_b[0] = pick(); op_a[1] = pick(); op_b[1] = pick();
        @(negedge clk);
        chk("abort_ptr_reset", 32'(req_ready), 32'd1);
        hs = req_valid & req_ready;

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    op_a[i] = pick();
                    op_b[i] = pick();
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = 2'($urandom_range(0, 3));
            @(negedge clk);
            hs = req_valid & req_ready;
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (30) @(posedge clk);
        #1;

        // LATENCY=1 instance: short latency, then ops_done wrap.
        do_op1(8'h80, 8'h80, 16'h4000, 16'h0001);
        @(negedge clk);
        force u_dut1.ops_done_q = 16'hFFFF;
        #2 release u_dut1.ops_done_q;
        @(negedge clk);
        chk("wrap_preload", 32'(s_ops_done), 32'hFFFF);
        @(posedge clk);
        #1;
        do_op1(8'h7F, 8'h80, 16'hC080, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        checks++;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
